// File: rtl/control_pipeline_if.sv
// Handshake/bus bundle between the instruction/hazard side and the control pipeline.
// The master drives the Decode inputs and ALU flags; the slave (control_pipeline)
// returns the per-stage control signals.
interface control_pipeline_if #(
  parameter int OPCODEWIDTH  = 4,
  parameter int ALUCTRLWIDTH = 3
);
  logic [OPCODEWIDTH-1:0]  opcodeD;
  logic                    validD;
  logic                    stallD;
  logic                    N;
  logic                    Z;
  logic                    V;
  logic                    C;
  logic                    obtainPCAsR1D;
  logic [ALUCTRLWIDTH-1:0] aluControlE;
  logic                    data2SelectorE;
  logic                    takeBranchE;
  logic                    PCSelectorF;
  logic                    writeDataEnableM;
  logic                    outFlagM;
  logic                    writeEnableW;
  logic                    resultSelectorW;
  logic [3:0]              flagsQ;
  logic                    illegalE;

  modport master (
    output opcodeD, validD, stallD, N, Z, V, C,
    input  obtainPCAsR1D, aluControlE, data2SelectorE, takeBranchE, PCSelectorF,
           writeDataEnableM, outFlagM, writeEnableW, resultSelectorW, flagsQ, illegalE
  );

  modport slave (
    input  opcodeD, validD, stallD, N, Z, V, C,
    output obtainPCAsR1D, aluControlE, data2SelectorE, takeBranchE, PCSelectorF,
           writeDataEnableM, outFlagM, writeEnableW, resultSelectorW, flagsQ, illegalE
  );
endinterface

// File: rtl/control_pipeline.sv
// Pipelined opcode decoder: decodes in Decode, carries the control bundle through
// Execute, Memory and Writeback, owns the NZVC flag register and resolves
// conditional branches in Execute against the registered flags.
module control_pipeline #(
  parameter int OPCODEWIDTH  = 4,
  parameter int ALUCTRLWIDTH = 3
) (
  input logic               clk,
  input logic               reset,
  control_pipeline_if.slave bus
);

  typedef struct packed {
    logic       write_en;
    logic       result_sel;
    logic       mem_write;
    logic       data2_sel;
    logic [2:0] alu;
    logic       out_flag;
    logic       branch;
    logic [2:0] cond;
    logic       flag_write;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic write_en;
    logic result_sel;
    logic mem_write;
    logic out_flag;
  } mem_ctrl_t;

  typedef struct packed {
    logic write_en;
    logic result_sel;
  } wb_ctrl_t;

  // Branch condition on the registered flags {N,Z,V,C}; codes are opcode[2:0].
  function automatic logic cond_met(input logic [2:0] cc, input logic [3:0] f);
    logic res;
    res = 1'b0;
    case (cc)
      3'b011:  res = 1'b1;           // B
      3'b100:  res = f[2];           // BEQ
      3'b101:  res = ~f[2];          // BNE
      3'b110:  res = f[3] ^ f[1];    // BLT
      3'b111:  res = ~(f[3] ^ f[1]); // BGE
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  ctrl_t     dec;
  ctrl_t     ctrl_e_d, ctrl_e_q;
  mem_ctrl_t ctrl_m_d, ctrl_m_q;
  wb_ctrl_t  ctrl_w_d, ctrl_w_q;
  logic [3:0] flags_d, flags_q;
  logic       take_branch;
  logic [ALUCTRLWIDTH-1:0] alu_ext;

  // ---- Decode stage ----
  // Combinational decode of the Decode-slot opcode; upper opcode bits make it illegal.
  always_comb begin
    dec = '0;
    if ((bus.opcodeD >> 4) != '0) begin
      dec.illegal = 1'b1;
    end else begin
      case (bus.opcodeD[3:0])
        4'h0: begin dec.write_en = 1'b1; dec.result_sel = 1'b1; dec.alu = 3'b110; end
        4'h1: begin dec.mem_write = 1'b1; dec.alu = 3'b110; end
        4'h2: begin dec.write_en = 1'b1; dec.data2_sel = 1'b1; dec.alu = 3'b111; end
        4'h3: begin dec.write_en = 1'b1; dec.alu = 3'b110; end
        4'h4: begin dec.out_flag = 1'b1; dec.alu = 3'b110; end
        4'h5: begin dec.write_en = 1'b1; dec.alu = 3'b000; end
        4'h6: begin dec.write_en = 1'b1; dec.alu = 3'b001; end
        4'h7: begin dec.write_en = 1'b1; dec.alu = 3'b010; end
        4'h8: begin dec.write_en = 1'b1; dec.alu = 3'b011; end
        4'h9: begin dec.write_en = 1'b1; dec.alu = 3'b100; end
        4'hA: begin dec.alu = 3'b001; dec.flag_write = 1'b1; end
        default: begin
          dec.branch    = 1'b1;
          dec.data2_sel = 1'b1;
          dec.alu       = 3'b000;
          dec.cond      = bus.opcodeD[2:0];
        end
      endcase
    end
  end

  // ---- Decode -> Execute boundary ----
  // Execute load priority: taken branch flushes, then stall/invalid inject a bubble.
  always_comb begin
    take_branch = ctrl_e_q.branch & cond_met(ctrl_e_q.cond, flags_q);
    ctrl_e_d    = '0;
    if (!take_branch && !bus.stallD && bus.validD) begin
      ctrl_e_d = dec;
    end
  end

  // ---- Execute -> Memory and Memory -> Writeback boundaries ----
  // Memory and Writeback always advance; CMP updates the flags from the live ALU outputs.
  always_comb begin
    ctrl_m_d.write_en   = ctrl_e_q.write_en;
    ctrl_m_d.result_sel = ctrl_e_q.result_sel;
    ctrl_m_d.mem_write  = ctrl_e_q.mem_write;
    ctrl_m_d.out_flag   = ctrl_e_q.out_flag;
    ctrl_w_d.write_en   = ctrl_m_q.write_en;
    ctrl_w_d.result_sel = ctrl_m_q.result_sel;
    flags_d             = flags_q;
    if (ctrl_e_q.flag_write) begin
      flags_d = {bus.N, bus.Z, bus.V, bus.C};
    end
  end

  // Stage and flag registers; reset loads bubbles and clears the flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_e_q <= '0;
      ctrl_m_q <= '0;
      ctrl_w_q <= '0;
      flags_q  <= '0;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      ctrl_m_q <= ctrl_m_d;
      ctrl_w_q <= ctrl_w_d;
      flags_q  <= flags_d;
    end
  end

  // Zero-extend the 3-bit ALU code onto the configurable control bus.
  always_comb begin
    alu_ext      = '0;
    alu_ext[2:0] = ctrl_e_q.alu;
  end

  assign bus.obtainPCAsR1D    = dec.branch;
  assign bus.aluControlE      = alu_ext;
  assign bus.data2SelectorE   = ctrl_e_q.data2_sel;
  assign bus.takeBranchE      = take_branch;
  assign bus.PCSelectorF      = take_branch;
  assign bus.illegalE         = ctrl_e_q.illegal;
  assign bus.writeDataEnableM = ctrl_m_q.mem_write;
  assign bus.outFlagM         = ctrl_m_q.out_flag;
  assign bus.writeEnableW     = ctrl_w_q.write_en;
  assign bus.resultSelectorW  = ctrl_w_q.result_sel;
  assign bus.flagsQ           = flags_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: each vector drives one cycle of inputs and
// queues the hand-computed outputs for that cycle; a negedge monitor pops and compares.
module tb_control_pipeline;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_push = 0;
  logic [16:0] exp_q [$];

  always #5 clk = ~clk;

  control_pipeline_if #(.OPCODEWIDTH(6), .ALUCTRLWIDTH(4)) bus ();

  control_pipeline #(.OPCODEWIDTH(6), .ALUCTRLWIDTH(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  // Packed observation: {op1, alu[3:0], d2, take, pcsel, wde, outf, we, rs, flags[3:0], ill}
  function automatic logic [16:0] observe();
    return {bus.obtainPCAsR1D, bus.aluControlE, bus.data2SelectorE, bus.takeBranchE,
            bus.PCSelectorF, bus.writeDataEnableM, bus.outFlagM, bus.writeEnableW,
            bus.resultSelectorW, bus.flagsQ, bus.illegalE};
  endfunction

  task automatic apply(input logic r, input logic [5:0] op, input logic vd, input logic sd,
                       input logic [3:0] nzvc, input logic op1, input logic [3:0] alu,
                       input logic d2, input logic tk, input logic wde, input logic of,
                       input logic we, input logic rs, input logic [3:0] fl, input logic ill);
    @(posedge clk);
    #1;
    rst         = r;
    bus.opcodeD = op;
    bus.validD  = vd;
    bus.stallD  = sd;
    {bus.N, bus.Z, bus.V, bus.C} = nzvc;
    exp_q.push_back({op1, alu, d2, tk, tk, wde, of, we, rs, fl, ill});
    n_push++;
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [16:0] e;
      logic [16:0] a;
      e = exp_q.pop_front();
      a = observe();
      n_vec++;
      if (a !== e) begin
        n_miss++;
        $display("FAIL vec%0d outputs act=%05h exp=%05h", n_vec - 1, a, e);
      end
    end
  end

  initial begin
    bus.opcodeD = 6'h03;
    bus.validD  = 1'b0;
    bus.stallD  = 1'b0;
    {bus.N, bus.Z, bus.V, bus.C} = 4'h0;
    repeat (2) @(posedge clk);
    //     r  op     v  s  nzvc  op1 alu  d2 tk wde of we rs fl   ill
    // reset then LOAD
    apply(1, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h00, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h6, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 1, 1, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    // CMP (Z=1,C=1), BEQ taken, MOV flushed
    apply(0, 6'h0A, 1, 0, 4'h5, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h0C, 1, 0, 4'h5, 1, 4'h1, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 1, 0, 4'h0, 0, 4'h0, 1, 1, 0, 0, 0, 0, 4'h5, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h5, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h5, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h5, 0);
    // CMP (Z=0), BEQ not taken, MOV writes back
    apply(0, 6'h0A, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h5, 0);
    apply(0, 6'h0C, 1, 0, 4'h0, 1, 4'h1, 0, 0, 0, 0, 0, 0, 4'h5, 0);
    apply(0, 6'h03, 1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h6, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 4'h0, 0);
    // ALU op 0111 stalled for two cycles
    apply(0, 6'h07, 1, 1, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h07, 1, 1, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h07, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h2, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 4'h0, 0);
    // illegal 010001, then OUT
    apply(0, 6'h11, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h04, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 1);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h6, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    // CMP sets flags 1010, STORE reaches Memory as reset is asserted
    apply(0, 6'h0A, 1, 0, 4'hA, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h01, 1, 0, 4'hA, 0, 4'h1, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h6, 0, 0, 0, 0, 0, 0, 4'hA, 0);
    apply(1, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 4'hA, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    // B always taken while the following MOV is also stalled: one bubble only
    apply(0, 6'h0B, 1, 0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 1, 1, 4'h0, 0, 4'h0, 1, 1, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h6, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 4'h0, 0);
    // flags 0000: BLT not taken, BGE taken
    apply(0, 6'h0E, 1, 0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h0F, 1, 0, 4'h0, 1, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 1, 1, 0, 0, 0, 0, 4'h0, 0);
    apply(0, 6'h03, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0 || n_vec != n_push) begin
      n_miss++;
      $display("FAIL drain compared=%0d required=%0d", n_vec, n_push);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/control_pipeline.md
# control_pipeline

Parametrised, pipelined successor to the processor's combinational opcode decoder. Decodes the opcode in Decode, carries the control bundle through registered Execute, Memory and Writeback stages, and holds the architectural NZVC flag register. Resolves conditional branches in Execute against that register and inserts bubbles on taken branches and on stalls. Sits between the instruction register, the hazard logic, and the datapath muxes, ALU and memory enables.

## Interface
- OPCODEWIDTH, 4: opcode field width, must be ≥ 4; the low 4 bits select the operation.
- ALUCTRLWIDTH, 3: width of the ALU control bus, must be ≥ 3; upper bits are always driven 0.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- opcodeD  in  OPCODEWIDTH  opcode of the instruction in Decode.
- validD  in  1  Decode holds a real instruction.
- stallD  in  1  hazard unit holds Decode; a bubble enters Execute this cycle.
- N, Z, V, C  in  1 each  ALU flags produced by the instruction in Execute.
- obtainPCAsR1D  out  1  combinational; Decode instruction is a branch (PC as operand 1).
- aluControlE  out  ALUCTRLWIDTH  ALU operation for the Execute instruction.
- data2SelectorE  out  1  selects the immediate as ALU operand 2.
- takeBranchE  out  1  combinational; the branch in Execute is taken.
- PCSelectorF  out  1  equals takeBranchE; Fetch loads the branch target.
- writeDataEnableM  out  1  memory write enable.
- outFlagM  out  1  output-port strobe.
- writeEnableW  out  1  register file write enable.
- resultSelectorW  out  1  1 selects memory data, 0 selects the ALU result.
- flagsQ  out  4  flag register {N,Z,V,C}.
- illegalE  out  1  the Execute slot holds an undecodable opcode, which is treated as a bubble.

## Operation
- Decode: if the opcode upper bits (above bit 3) are nonzero, the instruction is illegal. An illegal instruction is a bubble with the illegal bit set. Every field is fully specified; none is a don't-care.
- Low-4-bit decode, listed as {writeEn, resultSel, memWrite, data2Sel, alu, outFlag, branch}. All unlisted fields are 0.
  - 0000 LOAD: writeEn, resultSel=1, alu=110.
  - 0001 STORE: memWrite, alu=110.
  - 0010 MOVI: writeEn, data2Sel, alu=111.
  - 0011 MOV: writeEn, alu=110.
  - 0100 OUT: outFlag, alu=110.
  - 0101..1001 ALU ops: writeEn, alu = opcode − 5 (000..100).
  - 1010 CMP: alu=001, flagWrite.
  - 1011 B (always), 1100 BEQ (Z), 1101 BNE (!Z), 1110 BLT (N≠V), 1111 BGE (N=V): branch, data2Sel, alu=000, condition code = opcode[2:0].
- Execute register load, in priority order:
  - reset: bubble.
  - takeBranchE: bubble; this flushes the Decode instruction.
  - stallD or !validD: bubble.
  - otherwise: the decoded bundle.
- A bubble has every control field 0 and illegal 0. The exception is an illegal opcode, which is loaded as zero controls with illegal=1.
- Memory and Writeback registers always advance; they are never stalled.
- Branches and CMP carry no writes past Execute.
- takeBranchE = branchE and the condition evaluated on flagsQ, not on the live N, Z, V, C inputs.
- Flag register: loads {N,Z,V,C} at the clock edge while CMP occupies Execute. Otherwise it holds its value.

## Timing
- Reset: all stage registers hold bubbles, flagsQ=0000. Every registered output is 0 in the cycle after reset is sampled high. illegalE=0.
- A valid opcode in Decode at cycle t drives its E outputs in t+1, its M outputs in t+2, and its W outputs in t+3.
- Taken branch in Execute at cycle t: PCSelectorF=1 during t, and Execute holds a bubble at t+1.
- CMP in Execute at t is followed by a branch in Execute at t+1; the branch sees the updated flags with no extra cycle.
- Simultaneous stallD and takeBranchE: one bubble, no double effect.
- Reset asserted mid-stream: in-flight writes, stores and OUT strobes are cancelled from the next cycle.
- obtainPCAsR1D and takeBranchE are the only combinational paths.

## Test plan
- Reset, then LOAD in Decode with validD=1 at t0 → writeEnableW=1 and resultSelectorW=1 at t0+3, and 0 elsewhere. The intermediate outputs are aluControlE=110 at t0+1 and writeDataEnableM=0 at t0+2.
- CMP with ALU flags N=0, Z=1, V=0, C=1, followed by BEQ → flagsQ=0101 after the CMP. In the BEQ's Execute cycle takeBranchE=1 and PCSelectorF=1. The instruction behind it produces no writeEnableW.
- CMP with Z=0, followed by BEQ, then MOV → takeBranchE=0, and the MOV produces writeEnableW=1 three cycles after entering Decode.
- opcode 0111 with stallD=1 for 2 cycles, then 0 → two bubbles in Execute. aluControlE=010 appears only after the stall drops, followed by writeEnableW two cycles later.
- With OPCODEWIDTH=6, opcode 010001 → illegalE=1, and no write, store or OUT strobe occurs. Opcode 000100 → outFlagM=1 two cycles later.
- STORE in Memory when reset is asserted → writeDataEnableM=0 in the cycle after reset is sampled, and flagsQ=0000.
